trng_bit_collector: RTL and testbench

TRNG_BIT_COLLECTOR -- requirements
Module: trng_bit_collector

---
 rtl/trng_bit_collector.sv | 185 ++++++++++++++++++
 tb/tb_trng_bit_collector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/trng_bit_collector.sv
//------------------------------------------------------------------------------
// Module      : trng_bit_collector
// Description : Assembles qualified serial TRNG bits into words, runs a
//               repetition-count health test and buffers words in a small FIFO.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module trng_bit_collector #(
  parameter int         WORD_W     = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] REP_LIMIT  = 8'd32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          bit_in,
  input  logic                          bit_vld,
  output logic [WORD_W-1:0]             word_data,
  output logic                          word_vld,
  input  logic                          word_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          rep_fail
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [7:0]        rep_cnt_q, rep_cnt_d;
  logic              prev_bit_q, prev_bit_d;
  logic              overflow_q, overflow_d;
  logic              rep_fail_q, rep_fail_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];

  logic [WORD_W-1:0] shifted;
  logic [7:0]        rep_next;
  logic              word_done;
  logic              push;
  logic              pop;
  logic              full;

  // Right shift places the first bit of a word at bit 0 once the word is complete.
  assign shifted  = {bit_in, shift_q[WORD_W-1:1]};
  assign rep_next = (rep_cnt_q == 8'd0 || bit_in != prev_bit_q) ? 8'd1 : rep_cnt_q + 8'd1;
  assign full     = (level_q == LW'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rep_cnt_d  = rep_cnt_q;
    prev_bit_d = prev_bit_q;
    overflow_d = overflow_q;
    rep_fail_d = rep_fail_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    word_done  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        shift_d   = '0;
        rep_cnt_d = '0;
        if (en) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (!en) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          shift_d   = '0;
          rep_cnt_d = '0;
        end else if (bit_vld) begin
          rep_cnt_d  = rep_next;
          prev_bit_d = bit_in;
          // A failing bit kills its word even when it would complete it.
          if (rep_next == REP_LIMIT) begin
            state_d    = ST_FAULT;
            rep_fail_d = 1'b1;
            bit_cnt_d  = '0;
            shift_d    = '0;
            rep_cnt_d  = '0;
          end else if (bit_cnt_q == CW'(WORD_W - 1)) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            shift_d   = shifted;
          end
        end
      end
      ST_FAULT: begin
        bit_cnt_d = '0;
        shift_d   = '0;
        rep_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    pop  = (level_q != '0) && word_rdy;
    push = word_done && (!full || pop);
    if (word_done && full && !pop) overflow_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (clr) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      shift_d    = '0;
      rep_cnt_d  = '0;
      prev_bit_d = 1'b0;
      overflow_d = 1'b0;
      rep_fail_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      push       = 1'b0;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rep_cnt_q  <= '0;
      prev_bit_q <= 1'b0;
      overflow_q <= 1'b0;
      rep_fail_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rep_cnt_q  <= rep_cnt_d;
      prev_bit_q <= prev_bit_d;
      overflow_q <= overflow_d;
      rep_fail_q <= rep_fail_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shifted;
  end

  // Head is masked while empty so stale storage never shows after reset or clr.
  assign word_vld   = (level_q != '0);
  assign word_data  = word_vld ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign rep_fail   = rep_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_trng_bit_collector.sv
//------------------------------------------------------------------------------
// Module      : tb_trng_bit_collector
// Description : Directed self-checking bench for trng_bit_collector.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_trng_bit_collector;

  localparam int         WORD_W     = 32;
  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] REP_LIMIT  = 8'd32;

  logic              clk = 1'b0;
  logic              rstn;
  logic              en;
  logic              clr;
  logic              bit_in;
  logic              bit_vld;
  logic              word_rdy;
  logic [WORD_W-1:0] word_data;
  logic              word_vld;
  logic [2:0]        fifo_level;
  logic              overflow;
  logic              rep_fail;

  int n_checks = 0;
  int n_errors = 0;

  trng_bit_collector #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .REP_LIMIT  (REP_LIMIT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .clr        (clr),
    .bit_in     (bit_in),
    .bit_vld    (bit_vld),
    .word_data  (word_data),
    .word_vld   (word_vld),
    .word_rdy   (word_rdy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .rep_fail   (rep_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in  = b;
    bit_vld = 1'b1;
    tick();
    bit_vld = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] v, input logic rdy_last);
    for (int i = 0; i < 32; i++) begin
      bit_in   = v[i];
      bit_vld  = 1'b1;
      word_rdy = (i == 31) ? rdy_last : 1'b0;
      tick();
    end
    bit_vld  = 1'b0;
    word_rdy = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check(tag, word_data, exp);
    word_rdy = 1'b1;
    tick();
    word_rdy = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_level", fifo_level, 0);
    check("clr_vld", word_vld, 0);
    check("clr_ovf", overflow, 0);
    check("clr_rep", rep_fail, 0);
    tick();
  endtask

  initial begin
    rstn     = 1'b0;
    en       = 1'b0;
    clr      = 1'b0;
    bit_in   = 1'b0;
    bit_vld  = 1'b0;
    word_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", word_data, 0);
    check("rst_vld", word_vld, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rep", rep_fail, 0);
    rstn = 1'b1;
    en   = 1'b1;
    tick();

    // Alternating bits starting with 1
    for (int i = 0; i < 31; i++) send_bit(logic'(i % 2 == 0));
    check("alt_vld_early", word_vld, 0);
    send_bit(1'b0);
    check("alt_vld", word_vld, 1);
    check("alt_level", fifo_level, 1);
    pop_check("alt_data", 32'h5555_5555);
    check("alt_level_pop", fifo_level, 0);

    // Pop with empty FIFO has no effect
    word_rdy = 1'b1;
    tick();
    word_rdy = 1'b0;
    check("empty_pop_level", fifo_level, 0);

    // Overflow: five words into a depth-4 FIFO
    for (int w = 0; w < 4; w++) send_word(32'h3333_3333, 1'b0);
    check("full_level", fifo_level, 4);
    check("full_ovf", overflow, 0);
    send_word(32'h3333_3333, 1'b0);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_data", word_data, 32'h3333_3333);
    do_clr();

    // Full FIFO with simultaneous pop on completion of the fifth word
    send_word(32'h3333_3333, 1'b0);
    send_word(32'h5A5A_5A5A, 1'b0);
    send_word(32'hC3C3_C3C3, 1'b0);
    send_word(32'h0F0F_0F0F, 1'b0);
    check("sim_full_level", fifo_level, 4);
    tick();
    check("hold_data", word_data, 32'h3333_3333);
    send_word(32'hA5A5_A5A5, 1'b1);
    check("sim_level", fifo_level, 4);
    check("sim_ovf", overflow, 0);
    pop_check("order_1", 32'h5A5A_5A5A);
    pop_check("order_2", 32'hC3C3_C3C3);
    pop_check("order_3", 32'h0F0F_0F0F);
    pop_check("order_4", 32'hA5A5_A5A5);
    check("order_empty", fifo_level, 0);
    do_clr();

    // Repetition-count failure on 32 zeros
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    check("rep_early", rep_fail, 0);
    send_bit(1'b0);
    check("rep_fail", rep_fail, 1);
    check("rep_level", fifo_level, 0);
    send_word(32'h5555_5555, 1'b0);
    check("rep_ignored", fifo_level, 0);
    check("rep_sticky", rep_fail, 1);
    do_clr();

    // en drop mid-word discards the partial word
    for (int i = 0; i < 10; i++) send_bit(logic'(i % 2 == 0));
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    send_word(32'h5555_5555, 1'b0);
    check("endrop_level", fifo_level, 1);
    check("endrop_data", word_data, 32'h5555_5555);

    // Asynchronous reset mid-word with two words queued
    send_word(32'h1234_5678, 1'b0);
    check("prerst_level", fifo_level, 2);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_level", fifo_level, 0);
    check("arst_vld", word_vld, 0);
    check("arst_data", word_data, 0);
    check("arst_ovf", overflow, 0);
    check("arst_rep", rep_fail, 0);
    #5;
    rstn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
